mc_control: RTL

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_pkg.sv | 50 +++++
 rtl/mc_control.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: state encodings,
// opcode constants and datapath mux codes.
package mc_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned ST_W  = 4;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = 4'h0,
    S_DECODE = 4'h1,
    S_MEMADR = 4'h2,
    S_MEMRD  = 4'h3,
    S_MEMWB  = 4'h4,
    S_MEMWR  = 4'h5,
    S_EXEC   = 4'h6,
    S_RWB    = 4'h7,
    S_BEQ    = 4'h8,
    S_JUMP   = 4'h9,
    S_ERR    = 4'hA,
    S_RST    = 4'hF
  } state_e;

  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  // States whose exit to FETCH marks the end of an instruction.
  function automatic logic retires(input state_e s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RWB) ||
           (s == S_BEQ)   || (s == S_JUMP);
  endfunction

endpackage

// File: rtl/mc_control.sv
// Multicycle CPU main controller (Moore FSM) with retired-instruction counter.
// Inputs : clk, rst_n, opcode[5:0], memrdy, brn, nflag
// Outputs: datapath strobes (pcwrite .. alusrca), pcsource[1:0], alusrcb[1:0],
//          aluop1/aluop0, sticky err, debug state[3:0], instr_cnt[15:0]
module mc_control
  import mc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   opcode,
  input  logic              memrdy,
  input  logic              brn,
  input  logic              nflag,
  output logic              pcwrite,
  output logic              pcwritecond,
  output logic              iord,
  output logic              memread,
  output logic              memwrite,
  output logic              memtoreg,
  output logic              irwrite,
  output logic              regwrite,
  output logic              regdst,
  output logic              alusrca,
  output logic [1:0]        pcsource,
  output logic [1:0]        alusrcb,
  output logic              aluop1,
  output logic              aluop0,
  output logic              err,
  output logic [ST_W-1:0]   state,
  output logic [CNT_W-1:0]  instr_cnt
);

  state_e cur, nxt;

  // State register, sticky error flag and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= S_RST;
      err       <= 1'b0;
      instr_cnt <= '0;
    end else begin
      cur <= nxt;
      err <= err | (nxt == S_ERR);
      if ((nxt == S_FETCH) && retires(cur))
        instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  assign state = ST_W'(cur);

  // Next-state logic and state-decoded controls.
  always_comb begin
    nxt              = cur;
    pcwrite          = 1'b0;
    pcwritecond      = 1'b0;
    iord             = 1'b0;
    memread          = 1'b0;
    memwrite         = 1'b0;
    memtoreg         = 1'b0;
    irwrite          = 1'b0;
    regwrite         = 1'b0;
    regdst           = 1'b0;
    alusrca          = 1'b0;
    pcsource         = PCSRC_ALU;
    alusrcb          = SRCB_REG;
    {aluop1, aluop0} = ALUOP_ADD;

    case (cur)
      S_RST: nxt = S_FETCH;

      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = memrdy;
        pcwrite = memrdy;
        if (memrdy) nxt = S_DECODE;
      end

      S_DECODE: begin
        alusrcb = SRCB_SHIMM;
        case (opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXEC;
          OP_BEQ:       nxt = S_BEQ;
          OP_J:         nxt = S_JUMP;
          default:      nxt = S_ERR;
        endcase
      end

      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        // opcode[3] separates sw (101011) from lw (100011)
        nxt = opcode[3] ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (memrdy) nxt = S_MEMWB;
      end

      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (memrdy) nxt = S_FETCH;
      end

      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        nxt      = S_FETCH;
      end

      S_EXEC: begin
        alusrca          = 1'b1;
        {aluop1, aluop0} = ALUOP_RTYPE;
        nxt              = S_RWB;
      end

      // Branch-on-negative R-type: no register write, jump to register on N.
      S_RWB: begin
        regdst   = 1'b1;
        regwrite = ~brn;
        pcsource = brn ? PCSRC_REG : PCSRC_ALU;
        pcwrite  = brn & nflag;
        nxt      = S_FETCH;
      end

      S_BEQ: begin
        alusrca          = 1'b1;
        {aluop1, aluop0} = ALUOP_SUB;
        pcwritecond      = 1'b1;
        pcsource         = PCSRC_ALUOUT;
        nxt              = S_FETCH;
      end

      S_JUMP: begin
        pcwrite  = 1'b1;
        pcsource = PCSRC_JUMP;
        nxt      = S_FETCH;
      end

      S_ERR: nxt = S_ERR;

      default: nxt = S_ERR;
    endcase
  end

endmodule
